// File: rtl/adder_seg_display.sv
// Seven-segment display stage for the 2-bit adder: shows a, b and the sum on a
// multiplexed 8-digit display, with the carry on the decimal point of digit 0.
module adder_seg_display #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD       = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic [2:0] sum,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame
);

   localparam int unsigned CntW = $clog2(REFRESH_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
   localparam int GuardI = int'(GUARD);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [1:0]      a_s_q, a_s_d;
   logic [1:0]      b_s_q, b_s_d;
   logic [2:0]      sum_s_q, sum_s_d;
   logic            first_q;
   logic [7:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic            frame_q, frame_d;

   logic       tick;
   logic       load;
   logic       blank;
   logic [2:0] val;

   function automatic logic [6:0] decode(input logic [2:0] v);
      logic [6:0] s;
      case (v)
         3'd0: s = 7'h40;
         3'd1: s = 7'h79;
         3'd2: s = 7'h24;
         3'd3: s = 7'h30;
         3'd4: s = 7'h19;
         3'd5: s = 7'h12;
         3'd6: s = 7'h02;
         3'd7: s = 7'h78;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      tick  = (cnt_q == CntMax);
      // first_q marks the first cycle after reset release
      load  = first_q || (tick && (idx_q == 2'd3));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = tick ? idx_q + 2'd1 : idx_q;

      a_s_d   = load ? a   : a_s_q;
      b_s_d   = load ? b   : b_s_q;
      sum_s_d = load ? sum : sum_s_q;
      frame_d = load;

      blank = (int'({1'b0, cnt_q}) < GuardI);
      val   = 3'd0;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      unique case (idx_q)
         2'd0: begin
            val   = sum_s_q;
            seg_d = decode(val);
            dp_d  = ~sum_s_q[2];
         end
         2'd1: seg_d = 7'h7F;
         2'd2: begin
            val   = {1'b0, b_s_q};
            seg_d = decode(val);
         end
         2'd3: begin
            val   = {1'b0, a_s_q};
            seg_d = decode(val);
         end
         default: seg_d = 7'h7F;
      endcase
      an_d = blank ? 8'hFF : {4'hF, ~(4'b0001 << idx_q)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         a_s_q   <= 2'd0;
         b_s_q   <= 2'd0;
         sum_s_q <= 3'd0;
         first_q <= 1'b1;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         a_s_q   <= a_s_d;
         b_s_q   <= b_s_d;
         sum_s_q <= sum_s_d;
         first_q <= 1'b0;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_adder_seg_display.sv
// Randomized and directed bench for adder_seg_display, checked against a
// cycle-position model of the scan (REFRESH_DIV=8, GUARD=2, plus a GUARD=0 copy).
module tb_adder_seg_display;

   localparam int Div   = 8;
   localparam int Guard = 2;
   localparam int Frame = 4 * Div;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] a   = 2'd2;
   logic [1:0] b   = 2'd1;
   logic [2:0] sum = 3'd3;

   logic [7:0] an, an0;
   logic [6:0] seg, seg0;
   logic       dp, dp0, frame, frame0;

   int checks = 0;
   int errors = 0;

   // model state: cycles since reset release, and the snapshot held by the display
   int         pos = 0;
   logic [1:0] m_a = 2'd0;
   logic [1:0] m_b = 2'd0;
   logic [2:0] m_s = 3'd0;

   logic [6:0] seg_tbl [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

   always #5 clk = ~clk;

   adder_seg_display #(.REFRESH_DIV(Div), .GUARD(Guard)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum),
      .an(an), .seg(seg), .dp(dp), .frame(frame)
   );

   adder_seg_display #(.REFRESH_DIV(Div), .GUARD(0)) dut0 (
      .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum),
      .an(an0), .seg(seg0), .dp(dp0), .frame(frame0)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s pos=%0d observed %h expected %h", tag, pos, obs, exp);
      end
   endtask

   // One clock: predict what the edge produces, then compare after it.
   task automatic step();
      logic [7:0] e_an, e_an0;
      logic [6:0] e_seg;
      logic       e_dp, e_fr;
      int         c, d;
      if (rst) begin
         e_an = 8'hFF; e_an0 = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
         pos = 0; m_a = 2'd0; m_b = 2'd0; m_s = 3'd0;
      end else begin
         c = pos % Div;
         d = (pos / Div) % 4;
         e_an0 = ~(8'd1 << d);
         e_an  = (c < Guard) ? 8'hFF : e_an0;
         e_dp  = 1'b1;
         case (d)
            0: begin e_seg = seg_tbl[m_s]; e_dp = ~m_s[2]; end
            2: e_seg = seg_tbl[{1'b0, m_b}];
            3: e_seg = seg_tbl[{1'b0, m_a}];
            default: e_seg = 7'h7F;
         endcase
         e_fr = (pos == 0) || (pos % Frame == Frame - 1);
         if (e_fr) begin m_a = a; m_b = b; m_s = sum; end
         pos++;
      end
      @(posedge clk);
      #1;
      chk("an", an, e_an);
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp", {7'd0, dp}, {7'd0, e_dp});
      chk("frame", {7'd0, frame}, {7'd0, e_fr});
      chk("an_g0", an0, e_an0);
      chk("seg_g0", {1'b0, seg0}, {1'b0, e_seg});
      chk("dp_g0", {7'd0, dp0}, {7'd0, e_dp});
      chk("frame_g0", {7'd0, frame0}, {7'd0, e_fr});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // advance until the model's current cycle sits mid-way through digit window d
   task automatic run_to_digit(input int d);
      int guard_cnt;
      guard_cnt = 0;
      while (!(((pos / Div) % 4 == d) && (pos % Div == 3)) && guard_cnt < 2 * Frame) begin
         step();
         guard_cnt++;
      end
      chk("digit_reach", {7'd0, guard_cnt < 2 * Frame}, 8'd1);
   endtask

   initial begin
      // reset with mid-pattern inputs
      run(3);
      rst = 1'b0;
      run(2 * Frame);

      // mid-frame change during digit 2
      run_to_digit(2);
      a = 2'd1; b = 2'd0; sum = 3'd1;
      run(Frame + Frame / 2);

      // carry
      a = 2'd3; b = 2'd3; sum = 3'd6;
      run(Frame + 8);

      // reset mid-frame during digit 2
      run_to_digit(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      a = 2'd2; b = 2'd1; sum = 3'd3;
      run(Frame + 4);

      // random operands, occasional resets, sum covers value 7 too
      for (int k = 0; k < 24; k++) begin
         a   = 2'($urandom_range(0, 3));
         b   = 2'($urandom_range(0, 3));
         sum = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(a + b);
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            run($urandom_range(1, 3));
            rst = 1'b0;
         end
         run($urandom_range(1, 48));
      end
      run(Frame + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
